// File: rtl/mod_adsr_envelope_if.sv
// Stereo sample stream between the synth driver, the envelope stage and the DAC.
// The master drives raw samples in and observes the scaled samples coming back.
interface mod_adsr_envelope_if;
    logic        i_sample_valid;
    logic [31:0] i_sample;
    logic        o_sample_valid;
    logic [31:0] o_sample;

    modport master (
        output i_sample_valid,
        output i_sample,
        input  o_sample_valid,
        input  o_sample
    );

    modport slave (
        input  i_sample_valid,
        input  i_sample,
        output o_sample_valid,
        output o_sample
    );
endinterface

// File: rtl/mod_adsr_envelope.sv
// ADSR amplitude envelope that gates the stereo synth word with the note-on level.
// The envelope steps once per sample strobe and feeds a 2-stage multiply pipeline.
module mod_adsr_envelope #(
    parameter logic [15:0] ATTACK_STEP   = 16'h1000,
    parameter logic [15:0] DECAY_STEP    = 16'h0100,
    parameter logic [15:0] SUSTAIN_LEVEL = 16'hC000,
    parameter logic [15:0] RELEASE_STEP  = 16'h0200
) (
    input  logic               i_clk,
    input  logic               i_nrst,
    input  logic               i_gate,
    mod_adsr_envelope_if.slave bus,
    output logic [15:0]        o_env,
    output logic [2:0]         o_state,
    output logic               o_active
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] env;
    logic [15:0] env_nxt;
    logic        gate_q;
    logic        rise;
    logic        fall;
    logic [16:0] att_sum;
    logic [16:0] dec_diff;

    logic               s1_valid;
    logic [31:0]        s1_sample;
    logic [15:0]        s1_env;
    logic signed [32:0] env_ext;
    logic signed [32:0] prod_l;
    logic signed [32:0] prod_r;
    logic               unused_prod;

    // Envelope, state and gate history only move on a sample strobe.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state  <= IDLE;
            env    <= '0;
            gate_q <= 1'b0;
        end else if (bus.i_sample_valid) begin
            state  <= state_nxt;
            env    <= env_nxt;
            gate_q <= i_gate;
        end
    end

    always_comb begin
        rise      = i_gate & ~gate_q;
        fall      = ~i_gate & gate_q;
        att_sum   = {1'b0, env} + {1'b0, ATTACK_STEP};
        dec_diff  = {1'b0, env} - {1'b0, DECAY_STEP};
        state_nxt = state;
        env_nxt   = env;
        if (rise) begin
            state_nxt = ATTACK;
        end else if (fall && (state == ATTACK || state == DECAY || state == SUSTAIN)) begin
            state_nxt = RELEASE;
        end else begin
            case (state)
                ATTACK: begin
                    if (att_sum >= 17'h0FFFF) begin
                        env_nxt   = 16'hFFFF;
                        state_nxt = DECAY;
                    end else begin
                        env_nxt = att_sum[15:0];
                    end
                end
                DECAY: begin
                    if ($signed(dec_diff) <= $signed({1'b0, SUSTAIN_LEVEL})) begin
                        env_nxt   = SUSTAIN_LEVEL;
                        state_nxt = SUSTAIN;
                    end else begin
                        env_nxt = dec_diff[15:0];
                    end
                end
                SUSTAIN: env_nxt = SUSTAIN_LEVEL;
                RELEASE: begin
                    if (env <= RELEASE_STEP) begin
                        env_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        env_nxt = env - RELEASE_STEP;
                    end
                end
                IDLE:    env_nxt = '0;
                default: begin
                    env_nxt   = '0;
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        o_env    = env;
        o_state  = state;
        o_active = (state != IDLE);
    end

    // Stage 1 captures the envelope as it stood before this strobe's update.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            s1_valid  <= 1'b0;
            s1_sample <= '0;
            s1_env    <= '0;
        end else begin
            s1_valid <= bus.i_sample_valid;
            if (bus.i_sample_valid) begin
                s1_sample <= bus.i_sample;
                s1_env    <= env;
            end
        end
    end

    always_comb begin
        env_ext     = $signed({17'd0, s1_env});
        prod_l      = $signed({{17{s1_sample[31]}}, s1_sample[31:16]}) * env_ext;
        prod_r      = $signed({{17{s1_sample[15]}}, s1_sample[15:0]}) * env_ext;
        unused_prod = ^{prod_l[32], prod_l[15:0], prod_r[32], prod_r[15:0]};
    end

    // Bits [31:16] of the signed product are the floor of ch*env/65536.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            bus.o_sample_valid <= 1'b0;
            bus.o_sample       <= '0;
        end else begin
            bus.o_sample_valid <= s1_valid;
            if (s1_valid) begin
                bus.o_sample <= {prod_l[31:16], prod_r[31:16]};
            end
        end
    end

endmodule

// File: tb/tb_mod_adsr_envelope.sv
// Self-checking bench for mod_adsr_envelope: directed envelope walk with literal
// expectations, then randomized strobes/gate/reset against a behavioural model.
module tb_mod_adsr_envelope;
    localparam int A_STEP = 'h1000;
    localparam int D_STEP = 'h0100;
    localparam int S_LVL  = 'hC000;
    localparam int R_STEP = 'h0200;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        gate  = 1'b0;
    logic [15:0] env;
    logic [2:0]  state;
    logic        active;

    mod_adsr_envelope_if bus_if ();

    mod_adsr_envelope #(
        .ATTACK_STEP   (16'h1000),
        .DECAY_STEP    (16'h0100),
        .SUSTAIN_LEVEL (16'hC000),
        .RELEASE_STEP  (16'h0200)
    ) dut (
        .i_clk    (clk),
        .i_nrst   (rst_n),
        .i_gate   (gate),
        .bus      (bus_if),
        .o_env    (env),
        .o_state  (state),
        .o_active (active)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int bad    = 0;
    int pulses = 0;
    int cyc    = 0;

    // Model: envelope level as a plain integer, phase 0..4, last gate seen at a strobe.
    int          m_env   = 0;
    int          m_state = 0;
    bit          m_gate  = 1'b0;
    logic [31:0] last_out = '0;

    typedef struct {
        int          due;
        logic [31:0] val;
    } exp_t;
    exp_t q[$];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] scale(logic [15:0] ch, int e);
        longint p;
        p = longint'($signed(ch)) * longint'(e);
        p = p >>> 16;
        return p[15:0];
    endfunction

    task automatic model_reset();
        m_env    = 0;
        m_state  = 0;
        m_gate   = 1'b0;
        last_out = '0;
        q.delete();
    endtask

    task automatic model_step(bit g, logic [31:0] s);
        exp_t e;
        e.due = cyc + 1;
        e.val = {scale(s[31:16], m_env), scale(s[15:0], m_env)};
        q.push_back(e);
        if (g && !m_gate) begin
            m_state = 1;
        end else if (!g && m_gate && m_state >= 1 && m_state <= 3) begin
            m_state = 4;
        end else begin
            case (m_state)
                1: if (m_env + A_STEP >= 'hFFFF) begin m_env = 'hFFFF; m_state = 2; end
                   else m_env = m_env + A_STEP;
                2: if (m_env - D_STEP <= S_LVL) begin m_env = S_LVL; m_state = 3; end
                   else m_env = m_env - D_STEP;
                3: m_env = S_LVL;
                4: if (m_env <= R_STEP) begin m_env = 0; m_state = 0; end
                   else m_env = m_env - R_STEP;
                default: m_env = 0;
            endcase
        end
        m_gate = g;
    endtask

    task automatic model_tick();
        cyc = cyc + 1;
        if (bus_if.i_sample_valid) model_step(gate, bus_if.i_sample);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_tick();
    end

    task automatic compare_cycle();
        chk("env", env, m_env);
        chk("state", state, m_state);
        chk("active", active, m_state != 0);
        if (q.size() != 0 && q[0].due <= cyc) begin
            chk("valid", bus_if.o_sample_valid, 1);
            chk("sample", bus_if.o_sample, q[0].val);
            last_out = q[0].val;
            void'(q.pop_front());
        end else begin
            chk("valid", bus_if.o_sample_valid, 0);
        end
        chk("hold", bus_if.o_sample, last_out);
        if (bus_if.o_sample_valid) pulses++;
    endtask

    always @(negedge clk) if (rst_n) compare_cycle();

    task automatic drive(bit v, bit g, logic [31:0] s);
        bus_if.i_sample_valid = v;
        gate                  = g;
        bus_if.i_sample       = s;
        @(posedge clk);
        #1;
    endtask

    task automatic strobes(int n, bit g);
        repeat (n) drive(1'b1, g, $urandom);
    endtask

    initial begin
        int p0;
        bit g;
        bus_if.i_sample_valid = 1'b0;
        bus_if.i_sample       = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_env", env, 0);
        chk("rst_state", state, 0);
        chk("rst_valid", bus_if.o_sample_valid, 0);
        chk("rst_sample", bus_if.o_sample, 0);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, '0);

        // Attack from silence, then decay to sustain.
        drive(1'b1, 1'b1, $urandom);
        chk("rise_state", state, 1);
        chk("rise_env", env, 0);
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 1'b1, $urandom);
            chk("atk_env", env, (i < 16) ? i * 'h1000 : 'hFFFF);
        end
        chk("atk_state", state, 2);
        drive(1'b1, 1'b1, 32'h7FFF_8000);
        drive(1'b0, 1'b1, '0);
        chk("full_scale", bus_if.o_sample, 32'h7FFE_8000);
        strobes(63, 1'b1);
        chk("dec_env", env, 'hC000);
        chk("dec_state", state, 3);
        drive(1'b1, 1'b1, 32'h7FFF_8000);
        drive(1'b0, 1'b1, '0);
        chk("sustain_scale", bus_if.o_sample, 32'h5FFF_A000);

        // Release partway, back-to-back burst, retrigger from current level.
        drive(1'b1, 1'b0, $urandom);
        chk("fall_state", state, 4);
        chk("fall_env", env, 'hC000);
        strobes(40, 1'b0);
        repeat (2) drive(1'b0, 1'b0, '0);
        p0 = pulses;
        strobes(8, 1'b0);
        repeat (2) drive(1'b0, 1'b0, '0);
        chk("b2b_pulses", pulses - p0, 8);
        chk("rel_env", env, 'h6000);
        drive(1'b1, 1'b1, $urandom);
        chk("retrig_state", state, 1);
        chk("retrig_env", env, 'h6000);
        drive(1'b1, 1'b1, $urandom);
        chk("retrig_next", env, 'h7000);
        strobes(9, 1'b1);
        chk("retrig_peak", env, 'hFFFF);
        strobes(64, 1'b1);
        chk("retrig_sus", state, 3);

        // Asynchronous reset in the middle of a continuous strobe stream.
        strobes(4, 1'b1);
        bus_if.i_sample_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_sample", bus_if.o_sample, 0);
        chk("mid_rst_valid", bus_if.o_sample_valid, 0);
        chk("mid_rst_env", env, 0);
        chk("mid_rst_state", state, 0);
        @(posedge clk);
        #1 bus_if.i_sample_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(1'b0, 1'b0, '0);

        // Full release from sustain down to idle.
        drive(1'b1, 1'b1, $urandom);
        strobes(80, 1'b1);
        chk("to_sus", state, 3);
        drive(1'b1, 1'b0, $urandom);
        strobes(96, 1'b0);
        chk("rel_done_env", env, 0);
        chk("rel_done_state", state, 0);
        chk("rel_done_active", active, 0);
        drive(1'b1, 1'b0, 32'h7FFF_8000);
        drive(1'b0, 1'b0, '0);
        chk("idle_out", bus_if.o_sample, 0);

        // Randomized strobes, gate edges (some between strobes) and resets.
        g = 1'b0;
        repeat (4000) begin
            if ($urandom_range(0, 149) == 0) g = ~g;
            if ($urandom_range(0, 1999) == 0) begin
                rst_n = 1'b0;
                drive(1'b0, g, '0);
                rst_n = 1'b1;
            end
            drive($urandom_range(0, 3) != 0, g, $urandom);
        end
        repeat (3) drive(1'b0, g, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
